// File: rtl/nread_responder.sv
// SRIO target-side NREAD responder: HELLO NREAD in, AXI4 burst read, RESPONSE with data out.
// Define NREAD_RESP_STATS_EN to add saturating served/err/drop counters.
module nread_responder #(
    parameter logic [31:0] WIN_BASE      = 32'h0000_0000,
    parameter int          WIN_SIZE_LOG2 = 20,
    parameter int          MAX_DW        = 32
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_treq_tvalid,
    output logic        s_axis_treq_tready,
    input  logic        s_axis_treq_tlast,
    input  logic [63:0] s_axis_treq_tdata,
    input  logic [7:0]  s_axis_treq_tkeep,
    output logic        m_axis_tresp_tvalid,
    input  logic        m_axis_tresp_tready,
    output logic        m_axis_tresp_tlast,
    output logic [63:0] m_axis_tresp_tdata,
    output logic [7:0]  m_axis_tresp_tkeep,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
`ifdef NREAD_RESP_STATS_EN
    output logic [15:0] served_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt,
`endif
    output logic        resp_done
);

    localparam int          PW        = $clog2(MAX_DW + 1);
    localparam int          AW        = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;
    localparam logic [8:0]  MAX_DW9   = 9'(MAX_DW);
    localparam logic [34:0] WIN_LIMIT = 35'd1 << WIN_SIZE_LOG2;

    // state | meaning: IDLE accept header | DROP discard packet | CHECK validate | AR address
    // RDATA fill buffer | RSP_HDR/RSP_DATA data response | ERR_HDR error response
    typedef enum logic [2:0] {
        S_IDLE, S_DROP, S_CHECK, S_AR, S_RDATA, S_RSP_HDR, S_RSP_DATA, S_ERR_HDR
    } state_t;

    state_t       r_state;
    logic [7:0]   r_tid;
    logic [1:0]   r_prio;
    logic         r_crf;
    logic [7:0]   r_size;
    logic [33:0]  r_addr;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic         r_err;
    logic [63:0]  r_buf [MAX_DW];

    logic         w_is_nread;
    logic [8:0]   w_ndw;
    logic [8:0]   w_ndw_m1;
    logic [34:0]  w_end;
    logic         w_req_ok;
    logic [1:0]   w_rprio;
    logic         w_resp_hs;
    logic         w_rbeat;
    logic         w_wr;
    logic         w_data_last;
    logic         w_unused;

    assign w_is_nread = (s_axis_treq_tdata[55:52] == 4'h2) && (s_axis_treq_tdata[51:48] == 4'h4);
    // (SIZE+1)>>3 without a 9-bit add: the low three bits only carry when they are all ones
    assign w_ndw      = {4'b0, r_size[7:3]} + {8'b0, &r_size[2:0]};
    assign w_ndw_m1   = w_ndw - 9'd1;
    assign w_end      = {1'b0, r_addr} + {27'd0, r_size};
    assign w_req_ok   = (r_addr[2:0] == 3'b000) && (r_size[2:0] == 3'b111) &&
                        (w_ndw != 9'd0) && (w_ndw <= MAX_DW9) && (w_end < WIN_LIMIT);
    assign w_rprio    = (r_prio == 2'd3) ? 2'd3 : r_prio + 2'd1;
    assign w_resp_hs  = m_axis_tresp_tvalid && m_axis_tresp_tready;
    assign w_rbeat    = (r_state == S_RDATA) && m_axi_rvalid;
    assign w_wr       = w_rbeat && (9'(r_wptr) < w_ndw);
    assign w_data_last = (9'(r_rptr) == w_ndw_m1);
    assign w_unused   = ^{s_axis_treq_tkeep, s_axis_treq_tdata[47], s_axis_treq_tdata[35:34], w_ndw_m1[8]};

    assign s_axis_treq_tready  = !areset && ((r_state == S_IDLE) || (r_state == S_DROP));
    assign m_axi_arvalid       = (r_state == S_AR);
    assign m_axi_araddr        = WIN_BASE + r_addr[31:0];
    assign m_axi_arlen         = w_ndw_m1[7:0];
    assign m_axi_arsize        = 3'b011;
    assign m_axi_arburst       = 2'b01;
    assign m_axi_rready        = (r_state == S_RDATA);
    assign m_axis_tresp_tvalid = (r_state == S_RSP_HDR) || (r_state == S_RSP_DATA) || (r_state == S_ERR_HDR);
    assign m_axis_tresp_tkeep  = 8'hFF;
    assign busy                = (r_state != S_IDLE);
    assign resp_done           = !areset && w_resp_hs && m_axis_tresp_tlast;

    always_comb begin
        m_axis_tresp_tdata = 64'h0;
        m_axis_tresp_tlast = 1'b0;
        case (r_state)
            S_RSP_HDR:  m_axis_tresp_tdata = {r_tid, 4'hD, 4'h8, 1'b0, w_rprio, r_crf, 8'h00, 36'h0};
            S_RSP_DATA: begin
                m_axis_tresp_tdata = r_buf[r_rptr[AW-1:0]];
                m_axis_tresp_tlast = w_data_last;
            end
            S_ERR_HDR: begin
                m_axis_tresp_tdata = {r_tid, 4'hD, 4'h0, 1'b0, w_rprio, r_crf, 4'h0, 4'b0111, 36'h0};
                m_axis_tresp_tlast = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (w_wr) r_buf[r_wptr[AW-1:0]] <= m_axi_rdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_tid   <= '0;
            r_prio  <= '0;
            r_crf   <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (s_axis_treq_tvalid) begin
                    r_tid  <= s_axis_treq_tdata[63:56];
                    r_prio <= s_axis_treq_tdata[46:45];
                    r_crf  <= s_axis_treq_tdata[44];
                    r_size <= s_axis_treq_tdata[43:36];
                    r_addr <= s_axis_treq_tdata[33:0];
                    // a multi-beat NREAD is malformed and discarded like any foreign packet
                    if (!s_axis_treq_tlast)  r_state <= S_DROP;
                    else if (w_is_nread)     r_state <= S_CHECK;
                end
                S_DROP:  if (s_axis_treq_tvalid && s_axis_treq_tlast) r_state <= S_IDLE;
                S_CHECK: r_state <= w_req_ok ? S_AR : S_ERR_HDR;
                S_AR:    if (m_axi_arready) r_state <= S_RDATA;
                S_RDATA: if (m_axi_rvalid) begin
                    if (w_wr) r_wptr <= r_wptr + 1'b1;
                    if (m_axi_rresp != 2'b00) r_err <= 1'b1;
                    if (m_axi_rlast)
                        r_state <= (r_err || (m_axi_rresp != 2'b00)) ? S_ERR_HDR : S_RSP_HDR;
                end
                S_RSP_HDR: if (m_axis_tresp_tready) r_state <= S_RSP_DATA;
                S_RSP_DATA: if (m_axis_tresp_tready) begin
                    if (w_data_last) begin
                        r_state <= S_IDLE;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                        r_err   <= 1'b0;
                    end else begin
                        r_rptr  <= r_rptr + 1'b1;
                    end
                end
                S_ERR_HDR: if (m_axis_tresp_tready) begin
                    r_state <= S_IDLE;
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef NREAD_RESP_STATS_EN
    logic [15:0] r_served;
    logic [15:0] r_errs;
    logic [15:0] r_drops;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_served <= '0;
            r_errs   <= '0;
            r_drops  <= '0;
        end else begin
            if (w_resp_hs && (r_state == S_RSP_DATA) && w_data_last && (r_served != 16'hFFFF))
                r_served <= r_served + 16'd1;
            if (w_resp_hs && (r_state == S_ERR_HDR) && (r_errs != 16'hFFFF))
                r_errs <= r_errs + 16'd1;
            if ((r_state == S_IDLE) && s_axis_treq_tvalid && !w_is_nread && (r_drops != 16'hFFFF))
                r_drops <= r_drops + 16'd1;
        end
    end

    assign served_cnt = r_served;
    assign err_cnt    = r_errs;
    assign drop_cnt   = r_drops;
`endif

endmodule

// File: tb/tb_nread_responder.sv
// Randomized bench for nread_responder: AXI memory model, response scoreboard, stall checks.
module tb_nread_responder;

    localparam logic [31:0] WB = 32'h8000_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_treq_tvalid, s_axis_treq_tready, s_axis_treq_tlast;
    logic [63:0] s_axis_treq_tdata;
    logic [7:0]  s_axis_treq_tkeep;
    logic        m_axis_tresp_tvalid, m_axis_tresp_tready, m_axis_tresp_tlast;
    logic [63:0] m_axis_tresp_tdata;
    logic [7:0]  m_axis_tresp_tkeep;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        busy, resp_done;

    always #5 aclk = ~aclk;

    nread_responder #(.WIN_BASE(WB), .WIN_SIZE_LOG2(20), .MAX_DW(32)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_treq_tvalid(s_axis_treq_tvalid), .s_axis_treq_tready(s_axis_treq_tready),
        .s_axis_treq_tlast(s_axis_treq_tlast), .s_axis_treq_tdata(s_axis_treq_tdata),
        .s_axis_treq_tkeep(s_axis_treq_tkeep),
        .m_axis_tresp_tvalid(m_axis_tresp_tvalid), .m_axis_tresp_tready(m_axis_tresp_tready),
        .m_axis_tresp_tlast(m_axis_tresp_tlast), .m_axis_tresp_tdata(m_axis_tresp_tdata),
        .m_axis_tresp_tkeep(m_axis_tresp_tkeep),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .resp_done(resp_done)
    );

    int          vectors = 0;
    int          miscompares = 0;
    longint      cyc = 0;
    logic [63:0] exp_q[$];
    bit          exp_last_q[$];
    logic [39:0] exp_ar_q[$];
    int          inj_beat = -1;
    int          tready_pct = 100, arready_pct = 100, rvalid_pct = 100;
    int          beats_seen = 0, done_pulses = 0, ar_count = 0, r_beats = 0;
    logic [63:0] first_beat = '0;
    logic [31:0] last_araddr = '0;
    logic [7:0]  last_arlen = '0;
    longint      hdr_cyc = 0, ar_rise_cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [7:0] tid, input logic [3:0] ft, input logic [3:0] tt,
                                           input logic [1:0] prio, input logic crf, input logic [7:0] size,
                                           input logic [33:0] addr);
        return {tid, ft, tt, 1'b0, prio, crf, size, 2'b00, addr};
    endfunction

    // Reference model: what the responder must emit for one request packet.
    task automatic model_req(input logic [63:0] hdr, input int nbeats);
        logic [7:0]  tid;
        logic [1:0]  prio, rprio;
        logic        crf;
        logic [7:0]  size;
        logic [33:0] addr;
        int          ndw;
        bit          ok;
        if (hdr[55:52] != 4'h2 || hdr[51:48] != 4'h4 || nbeats != 1) return;
        tid  = hdr[63:56];
        prio = hdr[46:45];
        crf  = hdr[44];
        size = hdr[43:36];
        addr = hdr[33:0];
        rprio = (prio == 2'd3) ? 2'd3 : prio + 2'd1;
        ndw  = (int'(size) + 1) / 8;
        ok   = (addr % 8 == 0) && (size % 8 == 7) && ndw >= 1 && ndw <= 32 &&
               (longint'(addr) + longint'(size) < longint'(1 << 20));
        if (ok) exp_ar_q.push_back({WB + addr[31:0], 8'(ndw - 1)});
        if (!ok || (inj_beat >= 0 && inj_beat < ndw)) begin
            exp_q.push_back({tid, 4'hD, 4'h0, 1'b0, rprio, crf, 4'h0, 4'b0111, 36'h0});
            exp_last_q.push_back(1'b1);
        end else begin
            exp_q.push_back({tid, 4'hD, 4'h8, 1'b0, rprio, crf, 8'h00, 36'h0});
            exp_last_q.push_back(1'b0);
            for (int i = 0; i < ndw; i++) begin
                exp_q.push_back(mem_word(WB + addr[31:0] + 32'(8 * i)));
                exp_last_q.push_back(i == ndw - 1);
            end
        end
    endtask

    // Scoreboard and protocol checks, sampled away from the active edge.
    logic        prev_stall = 0, prev_ar_stall = 0, prev_arvalid = 0, prev_last = 0;
    logic [63:0] prev_data = '0;
    logic [39:0] prev_ar = '0;
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 0; prev_ar_stall = 0; prev_arvalid = 0;
        end else begin
            if (prev_stall) begin
                chk("tvalid_hold", m_axis_tresp_tvalid, 1);
                chk("tdata_hold", m_axis_tresp_tdata, prev_data);
                chk("tlast_hold", m_axis_tresp_tlast, prev_last);
            end
            if (m_axis_tresp_tvalid) chk("tkeep", m_axis_tresp_tkeep, 8'hFF);
            if (m_axis_tresp_tvalid && m_axis_tresp_tready) begin
                if (exp_q.size() == 0) flag("unexpected_beat", m_axis_tresp_tdata);
                else begin
                    logic [63:0] e;
                    bit          l;
                    e = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    chk("tdata", m_axis_tresp_tdata, e);
                    chk("tlast", m_axis_tresp_tlast, l);
                    chk("resp_done", resp_done, l);
                end
                if (beats_seen == 0) first_beat = m_axis_tresp_tdata;
                beats_seen++;
            end else begin
                chk("resp_done_quiet", resp_done, 0);
            end
            if (resp_done) done_pulses++;
            prev_stall = m_axis_tresp_tvalid && !m_axis_tresp_tready;
            prev_data  = m_axis_tresp_tdata;
            prev_last  = m_axis_tresp_tlast;

            if (prev_ar_stall) chk("ar_hold", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, prev_ar});
            if (m_axi_arvalid) begin
                chk("arsize", m_axi_arsize, 3'b011);
                chk("arburst", m_axi_arburst, 2'b01);
            end
            if (m_axi_arvalid && !prev_arvalid) ar_rise_cyc = cyc;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_count++;
                last_araddr = m_axi_araddr;
                last_arlen  = m_axi_arlen;
                if (exp_ar_q.size() == 0) flag("unexpected_ar", {m_axi_araddr, m_axi_arlen});
                else chk("ar_fields", {m_axi_araddr, m_axi_arlen}, exp_ar_q.pop_front());
            end
            if (m_axi_rvalid && m_axi_rready) r_beats++;
            prev_ar_stall = m_axi_arvalid && !m_axi_arready;
            prev_arvalid  = m_axi_arvalid;
            prev_ar       = {m_axi_araddr, m_axi_arlen};
        end
    end

    initial begin
        m_axis_tresp_tready = 0;
        forever begin
            @(posedge aclk); #1;
            m_axis_tresp_tready = ($urandom_range(0, 99) < tready_pct);
        end
    end

    // AXI read slave backed by mem_word(); one optional error beat per burst.
    initial begin
        logic [39:0] pend[$];
        logic [39:0] s_ar;
        bit          s_ar_hs, s_r_hs;
        int          bidx = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 0;
        forever begin
            @(negedge aclk);
            s_ar_hs = m_axi_arvalid && m_axi_arready;
            s_r_hs  = m_axi_rvalid && m_axi_rready;
            s_ar    = {m_axi_araddr, m_axi_arlen};
            @(posedge aclk); #1;
            if (areset) begin
                pend.delete();
                bidx = 0;
                m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_arready = 0;
            end else begin
                if (s_ar_hs) pend.push_back(s_ar);
                if (s_r_hs) begin
                    bidx++;
                    if (bidx > int'(pend[0][7:0])) begin
                        void'(pend.pop_front());
                        bidx = 0;
                    end
                end
                if (!(m_axi_rvalid && !s_r_hs)) begin
                    if (pend.size() > 0 && $urandom_range(0, 99) < rvalid_pct) begin
                        m_axi_rvalid = 1;
                        m_axi_rdata  = mem_word(pend[0][39:8] + 32'(bidx * 8));
                        m_axi_rresp  = (bidx == inj_beat) ? 2'b10 : 2'b00;
                        m_axi_rlast  = (bidx == int'(pend[0][7:0]));
                    end else begin
                        m_axi_rvalid = 0;
                        m_axi_rlast  = 0;
                    end
                end
                m_axi_arready = ($urandom_range(0, 99) < arready_pct);
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input bit last, output longint hs);
        int t = 0;
        s_axis_treq_tvalid = 1;
        s_axis_treq_tdata  = d;
        s_axis_treq_tlast  = last;
        @(negedge aclk);
        while (!s_axis_treq_tready && t < 3000) begin
            t++;
            @(negedge aclk);
        end
        if (t >= 3000) flag("treq_timeout", d);
        hs = cyc;
        @(posedge aclk); #1;
        s_axis_treq_tvalid = 0;
        s_axis_treq_tlast  = 0;
    endtask

    task automatic send_pkt(input logic [63:0] hdr, input int nbeats, input bit nogap);
        longint hs;
        model_req(hdr, nbeats);
        for (int i = 0; i < nbeats; i++) begin
            if (!nogap) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            send_beat((i == 0) ? hdr : {$urandom, $urandom}, i == nbeats - 1, hs);
            if (i == 0) hdr_cyc = hs;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge aclk);
        while ((exp_q.size() != 0 || exp_ar_q.size() != 0 || busy) && t < 5000) begin
            t++;
            @(negedge aclk);
        end
        if (t >= 5000) flag("idle_timeout", 64'(exp_q.size()));
        @(posedge aclk); #1;
    endtask

    task automatic clr_counts();
        beats_seen = 0; done_pulses = 0; ar_count = 0; r_beats = 0;
    endtask

    initial begin
        logic [7:0]  tid, size;
        logic [3:0]  ft;
        logic [1:0]  prio;
        logic        crf;
        logic [33:0] addr;
        int          mode, k, nb, t;

        #900_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  tid, size;
        logic [3:0]  ft;
        logic [1:0]  prio;
        logic        crf;
        logic [33:0] addr;
        int          mode, k, nb, t;

        areset = 1;
        s_axis_treq_tvalid = 0; s_axis_treq_tlast = 0; s_axis_treq_tdata = '0; s_axis_treq_tkeep = 8'hFF;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_treq_tready", s_axis_treq_tready, 0);
        chk("rst_tvalid", m_axis_tresp_tvalid, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_done", resp_done, 0);
        @(posedge aclk); #1;
        areset = 0;
        @(negedge aclk);
        chk("idle_treq_tready", s_axis_treq_tready, 1);
        @(posedge aclk); #1;

        // basic 8-doubleword read
        clr_counts();
        send_pkt(mk_hdr(8'h5A, 4'h2, 4'h4, 2'd1, 1'b0, 8'h3F, 34'h100), 1, 1);
        wait_idle();
        chk("t1_araddr", last_araddr, 32'h8000_0100);
        chk("t1_arlen", last_arlen, 8'd7);
        chk("t1_hdr", first_beat, 64'h5AD8_4000_0000_0000);
        chk("t1_beats", beats_seen, 9);
        chk("t1_done", done_pulses, 1);
        chk("t1_ar_latency", ar_rise_cyc - hdr_cyc, 2);

        // misaligned address: error, no AR
        clr_counts();
        send_pkt(mk_hdr(8'h33, 4'h2, 4'h4, 2'd3, 1'b1, 8'h3F, 34'h104), 1, 0);
        wait_idle();
        chk("t2_err_hdr", first_beat, 64'h33D0_7070_0000_0000);
        chk("t2_beats", beats_seen, 1);
        chk("t2_no_ar", ar_count, 0);
        chk("t2_done", done_pulses, 1);

        // slave error on beat 5 of a 32-beat burst
        clr_counts();
        inj_beat = 5;
        send_pkt(mk_hdr(8'h77, 4'h2, 4'h4, 2'd0, 1'b0, 8'hFF, 34'h2000), 1, 0);
        wait_idle();
        inj_beat = -1;
        chk("t3_r_beats", r_beats, 32);
        chk("t3_err_hdr", first_beat, 64'h77D0_2070_0000_0000);
        chk("t3_beats", beats_seen, 1);

        // NWRITE dropped, back-to-back NREAD served
        clr_counts();
        send_pkt(mk_hdr(8'h11, 4'h5, 4'h4, 2'd0, 1'b0, 8'h0F, 34'h0), 3, 1);
        send_pkt(mk_hdr(8'h12, 4'h2, 4'h4, 2'd2, 1'b0, 8'h1F, 34'h3000), 1, 1);
        wait_idle();
        chk("t4_beats", beats_seen, 5);
        chk("t4_done", done_pulses, 1);

        // window boundary: last fitting 256 B read, then one doubleword past it
        clr_counts();
        send_pkt(mk_hdr(8'h21, 4'h2, 4'h4, 2'd0, 1'b0, 8'hFF, 34'hF_FF00), 1, 0);
        wait_idle();
        chk("t5_edge_ok_beats", beats_seen, 33);
        clr_counts();
        send_pkt(mk_hdr(8'h22, 4'h2, 4'h4, 2'd0, 1'b0, 8'hFF, 34'hF_FF08), 1, 0);
        wait_idle();
        chk("t5_edge_bad_beats", beats_seen, 1);
        chk("t5_edge_bad_no_ar", ar_count, 0);

        // stalls everywhere on a 32-DW read
        clr_counts();
        tready_pct = 50; arready_pct = 40; rvalid_pct = 50;
        send_pkt(mk_hdr(8'h44, 4'h2, 4'h4, 2'd2, 1'b1, 8'hFF, 34'h8000), 1, 0);
        wait_idle();
        chk("t6_beats", beats_seen, 33);

        // reset while streaming data
        clr_counts();
        tready_pct = 30; arready_pct = 100; rvalid_pct = 100;
        send_pkt(mk_hdr(8'h55, 4'h2, 4'h4, 2'd0, 1'b0, 8'hFF, 34'h400), 1, 0);
        t = 0;
        while (beats_seen < 3 && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 3000) flag("t7_wait_timeout", 64'(beats_seen));
        @(posedge aclk); #1;
        areset = 1;
        @(posedge aclk);
        @(negedge aclk);
        chk("t7_tvalid_after_rst", m_axis_tresp_tvalid, 0);
        chk("t7_busy_after_rst", busy, 0);
        exp_q.delete(); exp_last_q.delete(); exp_ar_q.delete();
        repeat (2) @(posedge aclk);
        #1 areset = 0;
        @(posedge aclk); #1;
        clr_counts();
        tready_pct = 100;
        send_pkt(mk_hdr(8'h56, 4'h2, 4'h4, 2'd1, 1'b0, 8'h3F, 34'h40), 1, 0);
        wait_idle();
        chk("t7_post_rst_beats", beats_seen, 9);

        // randomized mix
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 9);
            tid  = 8'($urandom); prio = 2'($urandom); crf = 1'($urandom);
            k    = $urandom_range(1, 32);
            size = 8'(8 * k - 1);
            addr = 34'($urandom_range(0, (1 << 17) - 1)) * 34'd8;
            ft   = 4'h2; nb = 1;
            case (mode)
                0: begin ft = 4'($urandom_range(5, 6)); nb = $urandom_range(1, 4); end
                1: size = 8'($urandom);
                2: addr = addr | 34'($urandom_range(1, 7));
                3: addr = 34'((1 << 20) - (int'(size) + 1));
                4: addr = 34'((1 << 20) - (int'(size) + 1) + 8);
                5: addr = addr | (34'($urandom_range(1, 3)) << 32);
                default: ;
            endcase
            inj_beat    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, k + 1) : -1;
            tready_pct  = $urandom_range(30, 100);
            arready_pct = $urandom_range(30, 100);
            rvalid_pct  = $urandom_range(30, 100);
            send_pkt(mk_hdr(tid, ft, 4'h4, prio, crf, size, addr), nb, 0);
            wait_idle();
        end
        inj_beat = -1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
